// File: rtl/vending_pkg.sv
// ============================================================================
// Module : vending_pkg
// Brief  : Coin codes shared with vending_machine and coin_acceptor state map.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_QUAL   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_REJECT = 3'd4,
        ST_JAM    = 3'd5,
        ST_GAP    = 3'd6
    } ca_state_e;

endpackage

`default_nettype wire

// File: rtl/coin_acceptor_sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop synchroniser for one asynchronous level, async clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
// Module : coin_acceptor
// Brief  : Debounces two coin sensors into one-cycle coin codes with reject,
//          jam and inter-coin gap handling. Optional COIN_ACCEPTOR_CNT_EN
//          adds saturating accepted-coin counters cnt_a / cnt_b.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE   = 4,
    parameter int MAX_PULSE  = 64,
    parameter int GAP_CYCLES = 8
`ifdef COIN_ACCEPTOR_CNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sense_a,
    input  logic             sense_b,
    input  logic             accept_en,
    output logic [1:0]       coin,
    output logic             reject,
    output logic             jam,
    output logic             busy
`ifdef COIN_ACCEPTOR_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    localparam int QW = $clog2(DEBOUNCE) + 1;
    localparam int LW = $clog2(MAX_PULSE) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_PULSE - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    logic sa_s;
    logic sb_s;

    sync2 u_sync_a (.clk(clk), .rstn(rstn), .d(sense_a), .q(sa_s));
    sync2 u_sync_b (.clk(clk), .rstn(rstn), .d(sense_b), .q(sb_s));

    ca_state_e      state_q,     state_d;
    logic           type_b_q,    type_b_d;
    logic [QW-1:0]  qual_cnt_q,  qual_cnt_d;
    logic [LW-1:0]  len_cnt_q,   len_cnt_d;
    logic [GW-1:0]  gap_cnt_q,   gap_cnt_d;
    logic           jam_first_q, jam_first_d;
    logic [1:0]     coin_q,      coin_d;
    logic           reject_q,    reject_d;
    logic           jam_q,       jam_d;
    logic           busy_q,      busy_d;

    logic w_lat;
    logic w_oth;

    assign w_lat = type_b_q ? sb_s : sa_s;
    assign w_oth = type_b_q ? sa_s : sb_s;

    // qual_cnt doubles as the all-clear counter while in JAM
    always_comb begin
        state_d    = state_q;
        type_b_d   = type_b_q;
        qual_cnt_d = qual_cnt_q;
        len_cnt_d  = len_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sa_s && sb_s) begin
                    state_d    = ST_JAM;
                    qual_cnt_d = '0;
                end else if (sa_s ^ sb_s) begin
                    state_d    = ST_QUAL;
                    type_b_d   = sb_s;
                    qual_cnt_d = QW'(1);
                end
            end
            ST_QUAL: begin
                if (!w_lat) begin
                    state_d = ST_IDLE;
                end else if (w_oth) begin
                    state_d    = ST_JAM;
                    qual_cnt_d = '0;
                end else if (qual_cnt_q >= QUAL_LAST) begin
                    state_d   = ST_HOLD;
                    len_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            ST_HOLD: begin
                if (!w_lat) begin
                    state_d = accept_en ? ST_EMIT : ST_REJECT;
                end else if (w_oth || (len_cnt_q == LEN_LAST)) begin
                    state_d    = ST_JAM;
                    qual_cnt_d = '0;
                end else begin
                    len_cnt_d = len_cnt_q + LW'(1);
                end
            end
            ST_EMIT, ST_REJECT: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
            end
            ST_JAM: begin
                if (sa_s || sb_s) begin
                    qual_cnt_d = '0;
                end else if (qual_cnt_q >= QUAL_LAST) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the current state, one cycle behind it
    always_comb begin
        jam_first_d = (state_d == ST_JAM) && (state_q != ST_JAM);
        coin_d      = COIN_NONE;
        if (state_q == ST_EMIT) begin
            coin_d = type_b_q ? COIN_TWO : COIN_ONE;
        end
        reject_d = (state_q == ST_REJECT) || ((state_q == ST_JAM) && jam_first_q);
        jam_d    = (state_q == ST_JAM);
        busy_d   = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            type_b_q    <= 1'b0;
            qual_cnt_q  <= '0;
            len_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            jam_first_q <= 1'b0;
            coin_q      <= COIN_NONE;
            reject_q    <= 1'b0;
            jam_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_b_q    <= type_b_d;
            qual_cnt_q  <= qual_cnt_d;
            len_cnt_q   <= len_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            jam_first_q <= jam_first_d;
            coin_q      <= coin_d;
            reject_q    <= reject_d;
            jam_q       <= jam_d;
            busy_q      <= busy_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;
    assign busy   = busy_q;

`ifdef COIN_ACCEPTOR_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (state_q == ST_EMIT) begin
            if (type_b_q) begin
                if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

`default_nettype wire
